// File: rtl/weight_loader_param_2_pkg.sv
// Layer-2 shared constants for the weight loader.
// Holds the default parameter values used by the layer-2 blocks and a helper
// for sizing the pair counter. No ports; imported by the loader files.
package weight_loader_param_2_pkg;

  localparam int L2_WEIGHT_DATA_WIDTH   = 16;
  localparam int L2_WEIGHT_ADDR_WIDTH   = 10;
  localparam int L2_NUM_ONE_PIXEL_CYCLE = 26;
  localparam int L2_NUM_ONEMULT         = 1;

  // Bits needed to count pairs 0..total-1; never narrower than one bit.
  function automatic int pair_cnt_w(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/weight_loader_param_2_weight_pair_packer.sv
// Weight pair packer: joins two consecutive stream words into one RAM pair.
// The even word is parked in a hold register; the odd word completes the pair.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   i_clear        - zero pair counter and phase (start of a new load)
//   i_hs           - stream handshake this cycle
//   i_data         - stream word
//   o_phase        - 0: expecting even word, 1: expecting odd word
//   o_hold         - captured even word
//   o_pair         - index of the pair currently being assembled
//   o_last_pair    - o_pair is the final pair of the load
module weight_pair_packer #(
  parameter int DATA_W      = 16,
  parameter int PAIR_W      = 5,
  parameter int TOTAL_PAIRS = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_hs,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_phase,
  output logic [DATA_W-1:0] o_hold,
  output logic [PAIR_W-1:0] o_pair,
  output logic              o_last_pair
);

  logic              r_phase;
  logic [DATA_W-1:0] r_hold;
  logic [PAIR_W-1:0] r_pair;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= 1'b0;
      r_hold  <= '0;
      r_pair  <= '0;
    end else if (i_clear) begin
      r_phase <= 1'b0;
      r_pair  <= '0;
    end else if (i_hs) begin
      if (!r_phase) begin
        r_hold  <= i_data;
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        // Wrap explicitly so non-power-of-two pair counts stay in range.
        r_pair  <= o_last_pair ? '0 : r_pair + 1'b1;
      end
    end
  end

  assign o_phase     = r_phase;
  assign o_hold      = r_hold;
  assign o_pair      = r_pair;
  assign o_last_pair = (r_pair == PAIR_W'(TOTAL_PAIRS - 1));

endmodule

// File: rtl/weight_loader_param_2.sv
// Weight loader for layer 2: accepts TOTAL_PAIRS*2 weight words from a
// valid/ready stream and writes them into a dual-port weight RAM, one
// even/odd pair per write (port A even address, port B odd address).
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start                 - begin a load (ignored while loading)
//   s_valid/s_data/s_ready- weight word stream
//   wea/web               - single-cycle RAM write strobes
//   addra/addrb           - RAM addresses (2*pair, 2*pair+1)
//   dina/dinb             - RAM write data (even word, odd word)
//   busy                  - load in progress (same as s_ready)
//   done                  - load complete, held until next start
//   dbg_state             - current FSM state
// Handshake: a word transfers on a rising edge where s_valid && s_ready;
// s_valid low cycles have no effect. s_ready is high only in LOAD.
module weight_loader_param_2
  import weight_loader_param_2_pkg::*;
#(
  parameter int WEIGHT_DATA_WIDTH   = L2_WEIGHT_DATA_WIDTH,
  parameter int WEIGHT_ADDR_WIDTH   = L2_WEIGHT_ADDR_WIDTH,
  parameter int NUM_ONE_PIXEL_CYCLE = L2_NUM_ONE_PIXEL_CYCLE,
  parameter int NUM_ONEMULT         = L2_NUM_ONEMULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         s_valid,
  input  logic [WEIGHT_DATA_WIDTH-1:0] s_data,
  output logic                         s_ready,
  output logic                         wea,
  output logic                         web,
  output logic [WEIGHT_ADDR_WIDTH-1:0] addra,
  output logic [WEIGHT_ADDR_WIDTH-1:0] addrb,
  output logic [WEIGHT_DATA_WIDTH-1:0] dina,
  output logic [WEIGHT_DATA_WIDTH-1:0] dinb,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   dbg_state
);

  localparam int TOTAL_PAIRS = NUM_ONEMULT * NUM_ONE_PIXEL_CYCLE;
  localparam int PAIR_W      = pair_cnt_w(TOTAL_PAIRS);
  localparam int AW          = WEIGHT_ADDR_WIDTH;
  localparam int DW          = WEIGHT_DATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    DONE = ST_DONE
  } state_t;

  // The whole load must fit in the weight RAM address space.
  if (TOTAL_PAIRS * 2 > (1 << WEIGHT_ADDR_WIDTH)) begin : g_cfg_check
    $error("weight_loader_param_2: TOTAL_PAIRS*2 exceeds weight RAM depth");
  end

  state_t            r_state;
  logic              r_wea;
  logic              r_web;
  logic [AW-1:0]     r_addra;
  logic [AW-1:0]     r_addrb;
  logic [DW-1:0]     r_dina;
  logic [DW-1:0]     r_dinb;
  logic              r_done;

  logic              w_load;
  logic              w_hs;
  logic              w_odd_hs;
  logic              w_clear;
  logic              w_phase;
  logic [DW-1:0]     w_hold;
  logic [PAIR_W-1:0] w_pair;
  logic              w_last_pair;
  logic [AW-1:0]     w_addr_even;
  logic [AW-1:0]     w_addr_odd;

  assign w_load   = (r_state == LOAD);
  assign w_hs     = s_valid && w_load;
  assign w_odd_hs = w_hs && w_phase;
  // Starting a load (from IDLE or DONE) restarts pairing from scratch.
  assign w_clear  = start && !w_load;

  weight_pair_packer #(
    .DATA_W      (DW),
    .PAIR_W      (PAIR_W),
    .TOTAL_PAIRS (TOTAL_PAIRS)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_hs        (w_hs),
    .i_data      (s_data),
    .o_phase     (w_phase),
    .o_hold      (w_hold),
    .o_pair      (w_pair),
    .o_last_pair (w_last_pair)
  );

  // Pair k lands at 2k / 2k+1, which matches the consumer's
  // 2*(m*NUM_ONE_PIXEL_CYCLE+k) ordering since pairs stream map by map.
  assign w_addr_even = AW'({w_pair, 1'b0});
  assign w_addr_odd  = w_addr_even | AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wea   <= 1'b0;
      r_web   <= 1'b0;
      r_addra <= '0;
      r_addrb <= AW'(1);
      r_dina  <= '0;
      r_dinb  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_wea <= 1'b0;
      r_web <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) r_state <= LOAD;
        end
        LOAD: begin
          if (w_odd_hs) begin
            r_wea   <= 1'b1;
            r_web   <= 1'b1;
            r_addra <= w_addr_even;
            r_addrb <= w_addr_odd;
            r_dina  <= w_hold;
            r_dinb  <= s_data;
            if (w_last_pair) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state <= LOAD;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready   = w_load;
  assign busy      = w_load;
  assign wea       = r_wea;
  assign web       = r_web;
  assign addra     = r_addra;
  assign addrb     = r_addrb;
  assign dina      = r_dina;
  assign dinb      = r_dinb;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_weight_loader_param_2.sv
// Bench for weight_loader_param_2: default instance plus a NUM_ONEMULT=2
// instance, selected through a stimulus/observation mux.
module tb_weight_loader_param_2;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int EW = 2 * AW + 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus and mux ----------------
  logic          start_v, valid_v;
  logic [DW-1:0] data_v;
  int            sel;

  logic          d1_ready, d1_wea, d1_web, d1_busy, d1_done;
  logic [AW-1:0] d1_addra, d1_addrb;
  logic [DW-1:0] d1_dina, d1_dinb;
  logic [1:0]    d1_dbg;
  logic          d2_ready, d2_wea, d2_web, d2_busy, d2_done;
  logic [AW-1:0] d2_addra, d2_addrb;
  logic [DW-1:0] d2_dina, d2_dinb;
  logic [1:0]    d2_dbg;

  weight_loader_param_2 dut (
    .clk(clk), .reset(reset), .start(start_v && sel == 0),
    .s_valid(valid_v && sel == 0), .s_data(data_v), .s_ready(d1_ready),
    .wea(d1_wea), .web(d1_web), .addra(d1_addra), .addrb(d1_addrb),
    .dina(d1_dina), .dinb(d1_dinb), .busy(d1_busy), .done(d1_done),
    .dbg_state(d1_dbg)
  );

  weight_loader_param_2 #(.NUM_ONEMULT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start_v && sel == 1),
    .s_valid(valid_v && sel == 1), .s_data(data_v), .s_ready(d2_ready),
    .wea(d2_wea), .web(d2_web), .addra(d2_addra), .addrb(d2_addrb),
    .dina(d2_dina), .dinb(d2_dinb), .busy(d2_busy), .done(d2_done),
    .dbg_state(d2_dbg)
  );

  logic          m_ready, m_wea, m_web, m_busy, m_done;
  logic [AW-1:0] m_addra, m_addrb;
  logic [DW-1:0] m_dina, m_dinb;
  assign m_ready = (sel == 0) ? d1_ready : d2_ready;
  assign m_wea   = (sel == 0) ? d1_wea   : d2_wea;
  assign m_web   = (sel == 0) ? d1_web   : d2_web;
  assign m_busy  = (sel == 0) ? d1_busy  : d2_busy;
  assign m_done  = (sel == 0) ? d1_done  : d2_done;
  assign m_addra = (sel == 0) ? d1_addra : d2_addra;
  assign m_addrb = (sel == 0) ? d1_addrb : d2_addrb;
  assign m_dina  = (sel == 0) ? d1_dina  : d2_dina;
  assign m_dinb  = (sel == 0) ? d1_dinb  : d2_dinb;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] word_q[$];   // words offered in the current load
  logic [EW-1:0] exp_q[$];    // expected RAM pair writes
  logic [EW-1:0] obs_q[$];    // observed RAM pair writes
  int            wcyc_q[$];   // edge count at which each write was visible
  int            hs_q[$];     // edge count of each odd-word handshake
  int            strobe_bad = 0;
  int            tests_run = 0;
  int            fails = 0;

  // Monitor: records every strobe, away from the active edge.
  always @(negedge clk) begin
    if (m_wea || m_web) begin
      obs_q.push_back({m_addra, m_addrb, m_dina, m_dinb});
      wcyc_q.push_back(cyc);
      if (m_wea !== m_web) strobe_bad++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    word_q.delete(); exp_q.delete(); obs_q.delete();
    wcyc_q.delete(); hs_q.delete(); strobe_bad = 0;
  endtask

  task automatic make_words(input int n, input bit counting);
    word_q.delete();
    for (int i = 0; i < n; i++) word_q.push_back(counting ? DW'(i) : DW'($urandom));
  endtask

  // Reference: word 2k and 2k+1 land at addresses 2k and 2k+1.
  task automatic build_exp();
    exp_q.delete();
    for (int k = 0; k < word_q.size() / 2; k++)
      exp_q.push_back({AW'(2 * k), AW'(2 * k + 1), word_q[2 * k], word_q[2 * k + 1]});
  endtask

  task automatic do_start();
    start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
  endtask

  // mode 0: valid always, 1: valid toggles 1/0, 2: random valid.
  task automatic drive_words(input int n, input int mode, input int start_at,
                             output bit timed_out);
    int i = 0;
    int budget = 0;
    bit ph = 1'b1;
    bit accept;
    timed_out = 1'b0;
    while (i < n) begin
      case (mode)
        0:       valid_v = 1'b1;
        1:       begin valid_v = ph; ph = ~ph; end
        default: valid_v = 1'($urandom_range(0, 1));
      endcase
      data_v  = valid_v ? word_q[i] : DW'($urandom);
      start_v = (i == start_at) && valid_v;
      accept  = valid_v && m_ready;
      @(posedge clk); #1;
      if (accept) begin
        if (i % 2 == 1) hs_q.push_back(cyc);
        i++;
      end
      budget++;
      if (budget > 4000) begin
        timed_out = 1'b1;
        break;
      end
    end
    valid_v = 1'b0;
    start_v = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; #1;
    tests_run++;
    if (m_wea !== 1'b0 || m_web !== 1'b0) begin fails++; $display("FAIL reset_strobes got wea=%b web=%b want 0 0", m_wea, m_web); end
    tests_run++;
    if (m_addra !== AW'(0) || m_addrb !== AW'(1)) begin fails++; $display("FAIL reset_addr got %0d/%0d want 0/1", m_addra, m_addrb); end
    tests_run++;
    if (m_dina !== DW'(0) || m_dinb !== DW'(0)) begin fails++; $display("FAIL reset_din got %h/%h want 0/0", m_dina, m_dinb); end
    tests_run++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b0) begin fails++; $display("FAIL reset_flags got done=%b busy=%b ready=%b want 0 0 0", m_done, m_busy, m_ready); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // IDLE must ignore stream traffic.
    clear_sb();
    valid_v = 1'b1; data_v = 16'hBEEF;
    repeat (4) @(posedge clk);
    #1 valid_v = 1'b0;
    tests_run++;
    if (obs_q.size() != 0 || m_ready !== 1'b0) begin fails++; $display("FAIL idle_quiet got writes=%0d ready=%b want 0 0", obs_q.size(), m_ready); end
  endtask

  task automatic test_basic_load();
    bit to;
    clear_sb(); make_words(52, 1'b1); build_exp();
    do_start();
    tests_run++;
    if (m_busy !== 1'b1 || m_ready !== 1'b1) begin fails++; $display("FAIL basic_busy got busy=%b ready=%b want 1 1", m_busy, m_ready); end
    drive_words(52, 0, -1, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL basic_timeout got timeout want none"); end
    tests_run++;
    if (m_done !== 1'b1 || m_ready !== 1'b0 || m_busy !== 1'b0) begin fails++; $display("FAIL basic_done got done=%b ready=%b busy=%b want 1 0 0", m_done, m_ready, m_busy); end
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (obs_q.size() != 26) begin fails++; $display("FAIL basic_count got %0d want 26", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL basic_write[%0d] got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    for (int k = 0; k < hs_q.size() && k < wcyc_q.size(); k++) begin
      tests_run++;
      if (wcyc_q[k] !== hs_q[k]) begin fails++; $display("FAIL basic_latency[%0d] got edge %0d want edge %0d", k, wcyc_q[k], hs_q[k]); end
    end
    tests_run++;
    if (strobe_bad != 0 || m_done !== 1'b1) begin fails++; $display("FAIL basic_tail got strobe_bad=%0d done=%b want 0 1", strobe_bad, m_done); end
  endtask

  task automatic test_valid_toggle();
    bit to;
    clear_sb(); make_words(52, 1'b0); build_exp();
    do_start();
    drive_words(52, 1, -1, to);
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (to || obs_q.size() != 26) begin fails++; $display("FAIL toggle_count got %0d timeout=%b want 26 0", obs_q.size(), to); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL toggle_write[%0d] got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    for (int k = 1; k < wcyc_q.size(); k++) begin
      tests_run++;
      if (wcyc_q[k] - wcyc_q[k - 1] != 4) begin fails++; $display("FAIL toggle_spacing[%0d] got %0d want 4", k, wcyc_q[k] - wcyc_q[k - 1]); end
    end
    tests_run++;
    if (strobe_bad != 0 || m_done !== 1'b1) begin fails++; $display("FAIL toggle_tail got strobe_bad=%0d done=%b want 0 1", strobe_bad, m_done); end
  endtask

  task automatic test_start_in_load();
    bit to;
    clear_sb(); make_words(52, 1'b0); build_exp();
    do_start();
    drive_words(52, 0, 10, to);
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (to || obs_q.size() != 26) begin fails++; $display("FAIL start_in_load_count got %0d timeout=%b want 26 0", obs_q.size(), to); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL start_in_load_write[%0d] got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    tests_run++;
    if (m_done !== 1'b1) begin fails++; $display("FAIL start_in_load_done got %b want 1", m_done); end
  endtask

  task automatic test_reset_mid_load();
    bit to;
    clear_sb(); make_words(7, 1'b0);
    do_start();
    drive_words(7, 0, -1, to);
    reset = 1'b1; #1;
    tests_run++;
    if (m_wea !== 1'b0 || m_addra !== AW'(0) || m_addrb !== AW'(1) || m_dina !== DW'(0) || m_dinb !== DW'(0))
      begin fails++; $display("FAIL midreset_outputs got wea=%b a=%0d b=%0d da=%h db=%h want 0 0 1 0 0", m_wea, m_addra, m_addrb, m_dina, m_dinb); end
    tests_run++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b0) begin fails++; $display("FAIL midreset_flags got done=%b busy=%b ready=%b want 0 0 0", m_done, m_busy, m_ready); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (obs_q.size() != 3) begin fails++; $display("FAIL midreset_writes got %0d want 3", obs_q.size()); end
    // Fresh load after reset must begin at address 0.
    clear_sb(); make_words(52, 1'b0); build_exp();
    do_start();
    drive_words(52, 2, -1, to);
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (to || obs_q.size() != 26) begin fails++; $display("FAIL reload_count got %0d timeout=%b want 26 0", obs_q.size(), to); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL reload_write[%0d] got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    tests_run++;
    if (m_done !== 1'b1) begin fails++; $display("FAIL b2b_pre_done got %b want 1", m_done); end
    clear_sb(); make_words(52, 1'b0); build_exp();
    do_start();
    tests_run++;
    if (m_done !== 1'b0 || m_busy !== 1'b1) begin fails++; $display("FAIL b2b_restart got done=%b busy=%b want 0 1", m_done, m_busy); end
    drive_words(52, 2, -1, to);
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (to || obs_q.size() != 26) begin fails++; $display("FAIL b2b_count got %0d timeout=%b want 26 0", obs_q.size(), to); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL b2b_write[%0d] got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    tests_run++;
    if (m_done !== 1'b1 || strobe_bad != 0) begin fails++; $display("FAIL b2b_tail got done=%b strobe_bad=%0d want 1 0", m_done, strobe_bad); end
  endtask

  task automatic test_onemult2();
    bit to;
    sel = 1; #1;
    clear_sb(); make_words(104, 1'b0); build_exp();
    do_start();
    drive_words(104, 2, -1, to);
    tests_run++;
    if (m_done !== 1'b1 || m_ready !== 1'b0) begin fails++; $display("FAIL m2_done got done=%b ready=%b want 1 0", m_done, m_ready); end
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (to || obs_q.size() != 52) begin fails++; $display("FAIL m2_count got %0d timeout=%b want 52 0", obs_q.size(), to); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL m2_write[%0d] got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    tests_run++;
    if (m_addra !== AW'(102) || m_addrb !== AW'(103)) begin fails++; $display("FAIL m2_last_addr got %0d/%0d want 102/103", m_addra, m_addrb); end
    sel = 0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset = 1'b1; sel = 0;
    start_v = 1'b0; valid_v = 1'b0; data_v = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic_load();
    test_valid_toggle();
    test_start_in_load();
    test_back_to_back();
    test_reset_mid_load();
    test_onemult2();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
